// File: rtl/ifu_fetch_way1_if.sv
// Purpose: bundles the way-1 fetch stage's PC-unit, imem and decode handshake signals.
// Latency: none, wiring only.
// Backpressure: carries pc_ready_o, imem_gnt_i and inst_ready_i; no behaviour of its own.
interface ifu_fetch_way1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // PC unit side
  logic              pc_valid_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_ready_o;
  logic              flush_i;
  // instruction memory side
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  // decode side
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_ready_i;

  // Fetch stage view
  modport slave (
    input  pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );

  // Environment view (PC unit, memory and decode together)
  modport master (
    output pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o
  );
endinterface

// File: rtl/ifu_fetch_way1.sv
// Purpose: way-1 fetch stage; issues PCs to imem, pairs in-order responses with their PC, buffers for decode.
// Latency: a response in cycle N presents the instruction in cycle N+1; zero-bubble when the head is already done.
// Backpressure: requests issue only while allocated entries plus responses still to drop fit in DEPTH; decode stalls hold the head.
module ifu_fetch_way1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  ifu_fetch_way1_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  done_q;

  logic [PW-1:0] alloc_q, alloc_d, resp_q, resp_d, head_q, head_d;
  logic [CW-1:0] occ_q, occ_d, drop_q, drop_d, pend_q, pend_d;
  logic [CW-1:0] flush_drop;
  logic [CW:0]   credit_sum;
  logic          room, grant, pop, rsp_drop, rsp_keep;

  // Discarded responses still hold a credit, so they count against room.
  assign credit_sum = {1'b0, occ_q} + {1'b0, drop_q};
  assign room       = credit_sum < DEPTH_W;

  assign bus.imem_req_o  = bus.pc_valid_i & room & ~bus.flush_i & ~reset;
  assign bus.imem_addr_o = bus.pc_i;
  assign bus.pc_ready_o  = bus.imem_req_o & bus.imem_gnt_i;
  assign grant           = bus.pc_ready_o;

  assign bus.inst_valid_o = done_q[head_q] & (occ_q != '0) & ~bus.flush_i & ~reset;
  assign bus.inst_o       = data_q[head_q];
  assign bus.inst_addr_o  = addr_q[head_q];
  assign pop              = bus.inst_valid_o & bus.inst_ready_i;

  // A response first retires an outstanding drop; only then does it fill the oldest pending entry.
  assign rsp_drop = bus.imem_rvalid_i & (drop_q != '0);
  assign rsp_keep = bus.imem_rvalid_i & (drop_q == '0) & (pend_q != '0);

  // Every pending fetch becomes a future drop; a response landing in the flush cycle is one of them.
  assign flush_drop = drop_q + pend_q;

  // Next-state for pointers and counters; flush rewinds everything to the allocation point.
  always_comb begin
    alloc_d = alloc_q;
    resp_d  = resp_q;
    head_d  = head_q;
    occ_d   = occ_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (bus.flush_i) begin
      resp_d = alloc_q;
      head_d = alloc_q;
      occ_d  = '0;
      pend_d = '0;
      drop_d = flush_drop - CW'(bus.imem_rvalid_i && (flush_drop != '0));
    end else begin
      alloc_d = alloc_q + PW'(grant);
      resp_d  = resp_q + PW'(rsp_keep);
      head_d  = head_q + PW'(pop);
      occ_d   = occ_q + CW'(grant) - CW'(pop);
      pend_d  = pend_q + CW'(grant) - CW'(rsp_keep);
      drop_d  = drop_q - CW'(rsp_drop);
    end
  end

  // State registers and entry ring updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_q <= '0;
      resp_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      alloc_q <= alloc_d;
      resp_q  <= resp_d;
      head_q  <= head_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (bus.flush_i) begin
        done_q <= '0;
      end else begin
        // grant never targets the resp slot while anything is pending, so these writes cannot collide
        if (grant) begin
          addr_q[alloc_q] <= bus.pc_i;
          done_q[alloc_q] <= 1'b0;
        end
        if (rsp_keep) begin
          data_q[resp_q] <= bus.imem_rdata_i;
          done_q[resp_q] <= 1'b1;
        end
      end
    end
  end

  // A response with nothing pending and nothing to drop means the memory broke ordering.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rvalid_i && (drop_q == '0) && (pend_q == '0)));

endmodule
